// File: rtl/tomasulo_inst_queue.sv
// In-order instruction queue feeding the Tomasulo issue port.
// Buffers packed instruction words in a circular FIFO and decodes the
// head entry into issue fields. The fields stay stable until inst_ack.
// Also keeps an issued-instruction counter and a stall-cycle counter.
module tomasulo_inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [31:0]      wr_inst,
  output logic             wr_ready,
  output logic             inst_valid,
  output logic [2:0]       inst_op,
  output logic [3:0]       inst_rs,
  output logic [3:0]       inst_rt,
  output logic [3:0]       inst_rd,
  output logic [31:0]      inst_imm,
  input  logic             inst_ack,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic [15:0]      issue_count,
  output logic [15:0]      stall_count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [31:0]      head;
  logic             push;
  logic             pop;

  // Status comes from the occupancy counter, so full/empty never alias.
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign wr_ready   = !full;
  assign inst_valid = !empty;

  // Flush wins over both push and pop in the same cycle.
  assign push = wr_valid && !full && !flush;
  assign pop  = inst_valid && inst_ack && !flush;

  // Decode the head entry; fields are forced to zero while empty.
  always_comb begin
    head     = empty ? 32'd0 : mem[rp];
    inst_op  = head[31:29];
    inst_rs  = head[28:25];
    inst_rt  = head[24:21];
    inst_rd  = head[20:17];
    inst_imm = {{15{head[16]}}, head[16:0]};
  end

  // Storage array write; contents intentionally have no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= wr_inst;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Performance counters: issues wrap, stalls saturate; flush keeps both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      if (pop) issue_count <= issue_count + 16'd1;
      if (inst_valid && !inst_ack && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule
